tmds_channel_decoder: RTL
=========================

Name: tmds_channel_decoder

Overview:
Receive-side counterpart of the DVI/TMDS transmit path. One instance decodes one TMDS data channel. Input is unaligned 10-bit parallel words from an upstream deserializer, all in the pixel clock domain. The block finds the symbol boundary by hunting for control tokens (bit-slip), then decodes each aligned symbol into 8-bit pixel data, or into the control bits (hsync/vsync on channel 0) with a DE flag. Three instances plus a channel-deskew stage make up the future DVI receiver top.

Parameters:
LOCK_CNT, 8, consecutive control tokens required to declare lock
SEARCH_WIN, 2048, cycles spent at one bit offset before slipping to the next
LOSS_WIN, 4096, cycles in LOCKED with no LOCK_CNT-token run before lock is dropped

Ports:
hdmi_clk  in  1  pixel clock, single clock domain
sys_rst  in  1  synchronous reset, active-high
raw_sym  in  10  unaligned deserialized word, bit 0 earliest received
dout  out  8  decoded pixel byte
ctrl  out  2  decoded control bits {c1,c0}
de  out  1  1 = data symbol, 0 = control token
locked  out  1  symbol alignment established
bit_offset  out  4  current slip offset, 0..9

Behaviour:
- Clock and reset: one clock (hdmi_clk); reset sys_rst is synchronous and active-high.
- Reset values: dout=0, ctrl=0, de=0, locked=0, bit_offset=0. FSM=SEARCH, all counters 0, pipeline registers 0.
- Stage 0: raw_d <= raw_sym.
- Stage 1: window = {raw_sym, raw_d} (20 bits). sym_r <= window[bit_offset +: 10].
- Stage 2: outputs are registered from sym_r.
- Latency: a word applied on raw_sym at edge t appears decoded after edge t+3 (offset 0).
- Token detect on sym_r: 10'h354 -> ctrl=00; 10'h0AB -> ctrl=01; 10'h154 -> ctrl=10; 10'h2AB -> ctrl=11.
- Token symbol and locked=1: de=0, ctrl=token value, dout=0.
- Data decode (non-token symbol, locked=1):
  - d = sym_r[9] ? ~sym_r[7:0] : sym_r[7:0].
  - dout[0] = d[0].
  - For i=1..7: dout[i] = sym_r[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
  - de=1; ctrl holds its last token value.
- While locked=0: de=0, dout=0, ctrl=0, regardless of symbol.
- FSM states SEARCH and LOCKED:
  - tok_run counts consecutive token cycles; any non-token clears it.
  - win_cnt counts cycles.
- SEARCH transitions:
  - tok_run reaching LOCK_CNT -> LOCKED, locked=1 on the next edge, win_cnt=0.
  - Else win_cnt == SEARCH_WIN-1 -> bit_offset = (bit_offset==9) ? 0 : bit_offset+1; win_cnt=0, tok_run=0.
  - Token run completing on the same cycle as window expiry: lock wins, no slip.
  - Slip settling: tok_run is also held at 0 for 2 cycles after a slip so stale pipeline symbols are not counted.
- LOCKED transitions:
  - Every completed LOCK_CNT-token run resets win_cnt.
  - win_cnt == LOSS_WIN-1 -> SEARCH, locked=0, bit_offset unchanged, counters 0.
- Reset asserted mid-lock: everything returns to reset values on that edge, including bit_offset=0.
- Counter widths: win_cnt is clog2(max(SEARCH_WIN,LOSS_WIN)) bits; tok_run is clog2(LOCK_CNT+1) bits and saturates.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants (shared with the encoder);
  - the FSM state typedef;
  - the symbol width constant 10.
- One natural sub-module: tmds_sym_decode.
  - Combinational 10b->8b/token decode with outputs dout, ctrl, is_token.
  - Instantiated at stage 2 and reused for token detection.
- Alignment FSM and barrel select stay in the top.

Test Plan:
1. Offset-0 lock:
   - Stimulus: reset, then continuous 10'h354 words.
   - Response: locked=1 exactly LOCK_CNT+3 cycles after the first word; bit_offset=0; de=0, ctrl=00.
2. Offset-3 lock:
   - Stimulus: a 10'h0AB token stream shifted by 3 bits.
   - Response: bit_offset steps 0->1->2->3 at SEARCH_WIN-cycle intervals; locks at 3; ctrl=01.
3. Data decode:
   - Stimulus: after lock, send 10'h100, then 10'h2FF.
   - Response: dout=8'h00 with de=1, then dout=8'hFE with de=1; ctrl keeps the last token value.
4. Wrap-around:
   - Stimulus: stream with no tokens for 10*SEARCH_WIN cycles.
   - Response: bit_offset goes 9->0; locked stays 0 and de=0 throughout.
5. Loss of lock:
   - Stimulus: lock, then LOSS_WIN cycles of data symbols only.
   - Response: locked falls to 0 on cycle LOSS_WIN and de=0. Resuming tokens relocks at the same bit_offset.
6. Reset mid-lock:
   - Stimulus: assert sys_rst for 1 cycle while locked at offset 5.
   - Response: next cycle shows locked=0, bit_offset=0, dout=0, de=0.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, symbol width, alignment FSM states.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;

    // Control tokens, shared with the transmit-side encoder
    localparam logic [SYM_W-1:0] TOK_C00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_C01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_C10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_C11 = 10'h2AB;

    typedef logic [0:0] state_t;

    localparam state_t ST_SEARCH = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

endpackage

// File: rtl/tmds_sym_decode.sv
// Combinational 10b symbol decode: control-token match or 8b pixel data.
module tmds_sym_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic [7:0]       dout,
    output logic [1:0]       ctrl,
    output logic             is_token
);

    logic [7:0] d;

    // Token match and transition-minimised data recovery
    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        dout     = 8'h00;
        d        = sym[9] ? ~sym[7:0] : sym[7:0];
        case (sym)
            TOK_C00: ctrl = 2'b00;
            TOK_C01: ctrl = 2'b01;
            TOK_C10: ctrl = 2'b10;
            TOK_C11: ctrl = 2'b11;
            default: begin
                is_token = 1'b0;
                dout[0]  = d[0];
                for (int i = 1; i < 8; i++) begin
                    dout[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS data channel receiver: bit-slip alignment on control tokens plus symbol decode.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned SEARCH_WIN = 2048,
    parameter int unsigned LOSS_WIN   = 4096
) (
    input  logic             hdmi_clk,
    input  logic             sys_rst,
    input  logic [SYM_W-1:0] raw_sym,
    output logic [7:0]       dout,
    output logic [1:0]       ctrl,
    output logic             de,
    output logic             locked,
    output logic [3:0]       bit_offset
);

    localparam int unsigned WIN_MAX    = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
    localparam int unsigned WIN_W      = $clog2(WIN_MAX);
    localparam int unsigned RUN_W      = $clog2(LOCK_CNT + 1);
    localparam int unsigned OFF_W      = 4;
    localparam int unsigned SETTLE_W   = 2;
    localparam int unsigned SETTLE_CYC = 2;

    logic [SYM_W-1:0]   raw_d;
    logic [SYM_W-1:0]   sym_r;
    logic [2*SYM_W-1:0] window;
    logic [SYM_W-1:0]   sym_sel;

    state_t              state,       state_nxt;
    logic [RUN_W-1:0]    tok_run,     tok_run_nxt;
    logic [WIN_W-1:0]    win_cnt,     win_cnt_nxt;
    logic [OFF_W-1:0]    bit_offset_nxt;
    logic [SETTLE_W-1:0] settle,      settle_nxt;

    logic [7:0] dec_dout;
    logic [1:0] dec_ctrl;
    logic       dec_is_token;

    assign window  = {raw_sym, raw_d};
    assign sym_sel = SYM_W'(window >> bit_offset);

    // Two-stage capture: previous word, then barrel-selected aligned symbol
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            raw_d <= '0;
            sym_r <= '0;
        end else begin
            raw_d <= raw_sym;
            sym_r <= sym_sel;
        end
    end

    tmds_sym_decode u_sym_decode (
        .sym      (sym_r),
        .dout     (dec_dout),
        .ctrl     (dec_ctrl),
        .is_token (dec_is_token)
    );

    // Alignment state registers
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            state      <= ST_SEARCH;
            tok_run    <= '0;
            win_cnt    <= '0;
            bit_offset <= '0;
            settle     <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            tok_run    <= tok_run_nxt;
            win_cnt    <= win_cnt_nxt;
            bit_offset <= bit_offset_nxt;
            settle     <= settle_nxt;
            locked     <= (state_nxt == ST_LOCKED);
        end
    end

    // Token-run counting, slip search and loss-of-lock watchdog
    always_comb begin
        state_nxt      = state;
        win_cnt_nxt    = win_cnt + WIN_W'(1);
        bit_offset_nxt = bit_offset;
        settle_nxt     = (settle != '0) ? settle - SETTLE_W'(1) : settle;
        if ((settle != '0) || !dec_is_token) begin
            tok_run_nxt = '0;
        end else if (tok_run == RUN_W'(LOCK_CNT)) begin
            tok_run_nxt = tok_run;
        end else begin
            tok_run_nxt = tok_run + RUN_W'(1);
        end

        case (state)
            ST_SEARCH: begin
                if (tok_run == RUN_W'(LOCK_CNT)) begin
                    state_nxt   = ST_LOCKED;
                    win_cnt_nxt = '0;
                end else if (win_cnt == WIN_W'(SEARCH_WIN - 1)) begin
                    bit_offset_nxt = (bit_offset == OFF_W'(9)) ? '0 : bit_offset + OFF_W'(1);
                    win_cnt_nxt    = '0;
                    tok_run_nxt    = '0;
                    // stale symbols from the old offset are still in the pipe
                    settle_nxt     = SETTLE_W'(SETTLE_CYC);
                end
            end
            ST_LOCKED: begin
                if (tok_run == RUN_W'(LOCK_CNT)) begin
                    win_cnt_nxt = '0;
                end else if (win_cnt == WIN_W'(LOSS_WIN - 1)) begin
                    state_nxt   = ST_SEARCH;
                    win_cnt_nxt = '0;
                    tok_run_nxt = '0;
                    settle_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
            end
        endcase
    end

    // Output stage: blanked while unlocked, ctrl holds across data periods
    always_ff @(posedge hdmi_clk) begin
        if (sys_rst) begin
            dout <= 8'h00;
            ctrl <= 2'b00;
            de   <= 1'b0;
        end else if (!locked) begin
            dout <= 8'h00;
            ctrl <= 2'b00;
            de   <= 1'b0;
        end else if (dec_is_token) begin
            dout <= 8'h00;
            ctrl <= dec_ctrl;
            de   <= 1'b0;
        end else begin
            dout <= dec_dout;
            de   <= 1'b1;
        end
    end

endmodule
